cotm32_dmem_responder: RTL

- Memory-side responder for the core's data-memory request/response interface; the load/store path is the initiator and this block is the slave serving it.
- Holds a word-organised RAM of DEPTH_WORDS x XLEN bits.
- Accepts one request at a time, inserts WAIT_CYCLES wait states, applies byte-strobed writes, returns read data, and flags misaligned or out-of-range accesses.
- Used as on-chip data RAM and as the reference slave for LSU verification.

---
 rtl/cotm32_dmem_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cotm32_dmem_responder.sv
// Word-organised data RAM slave: one request at a time, WAIT_CYCLES wait states, byte-strobed writes, fault on misaligned/out-of-range.
// Latency: response visible at edge accept+1+WAIT_CYCLES; backpressure: rsp held until rsp_ready, req_ready low outside IDLE.
module cotm32_dmem_responder #(
  parameter int XLEN = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic              req_we,
  input  logic [XLEN/8-1:0] req_wstrb,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int SW = XLEN / 8;
  localparam logic [XLEN-3:0] DEPTH_LIM = (XLEN-2)'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            we_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            in_idle;
  logic            acc_fire;
  logic            acc_fault;
  logic            mem_we;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] acc_off;
  logic [XLEN-1:0] acc_wdata;
  logic [SW-1:0]   acc_wstrb;
  logic            acc_we;
  logic [AW-1:0]   acc_idx;
  logic [XLEN-1:0] acc_rdata;

  assign req_ready = (state == IDLE);

  // With zero wait states the access uses the live request on the accept edge.
  always_comb begin
    in_idle   = (state == IDLE);
    acc_addr  = in_idle ? req_addr  : addr_q;
    acc_wdata = in_idle ? req_wdata : wdata_q;
    acc_wstrb = in_idle ? req_wstrb : wstrb_q;
    acc_we    = in_idle ? req_we    : we_q;
    acc_fire  = (in_idle && req_valid && (WAIT_CYCLES == 0)) ||
                ((state == WAIT) && (wait_cnt == 4'd0));
    acc_off   = acc_addr - BASE_ADDR;
    // Lower bound checked on the raw address so the subtraction cannot wrap into range.
    acc_fault = (acc_off[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                (acc_off[XLEN-1:2] >= DEPTH_LIM);
    acc_idx   = acc_off[AW+1:2];
    mem_we    = rst_n && acc_fire && acc_we && !acc_fault;
    acc_rdata = (acc_fault || acc_we) ? '0 : mem[acc_idx];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < SW; i++) begin
        if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            we_q    <= req_we;
            if (WAIT_CYCLES != 0) begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (acc_fire) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= acc_rdata;
        rsp_err   <= acc_fault;
      end
    end
  end

endmodule
